// File: rtl/retention_pkg.sv
// -----------------------------------------------------------------------------
// retention_pkg
// Shared types for the retention power controller.
//   ret_state_e : FSM state enum with its 4-bit encoding (visible on the state port)
//   ret_ctrl_t  : bundle of the registered control/status outputs
//   ret_decode  : per-state output table, evaluated on the next state so every
//                 output leaves the block straight from a flop
// -----------------------------------------------------------------------------
package retention_pkg;

    typedef enum logic [3:0] {
        ST_ACTIVE  = 4'd0,
        ST_SAVE    = 4'd1,
        ST_CLK_OFF = 4'd2,
        ST_ISO_ON  = 4'd3,
        ST_PWR_OFF = 4'd4,
        ST_SLEEP   = 4'd5,
        ST_PWR_ON  = 4'd6,
        ST_SETTLE  = 4'd7,
        ST_CLK_ON  = 4'd8,
        ST_RESTORE = 4'd9,
        ST_ISO_OFF = 4'd10
    } ret_state_e;

    typedef struct packed {
        logic clk_en;
        logic pwr_en;
        logic iso_en;
        logic save;
        logic restore;
        logic asleep;
        logic busy;
    } ret_ctrl_t;

    localparam ret_ctrl_t RET_CTRL_RESET = '{clk_en: 1'b1, pwr_en: 1'b1, default: 1'b0};

    // Isolation is raised together with the clock gate (CLK_OFF) and dropped
    // only once the clock is back (ISO_OFF), so iso_en covers every cycle in
    // which the clock is gated or the switch is open.
    function automatic ret_ctrl_t ret_decode(input ret_state_e st);
        ret_ctrl_t c;
        c      = '0;
        c.busy = 1'b1;
        case (st)
            ST_ACTIVE:  begin c.clk_en = 1'b1; c.pwr_en = 1'b1; c.busy = 1'b0; end
            ST_SAVE:    begin c.clk_en = 1'b1; c.pwr_en = 1'b1; c.save = 1'b1; end
            ST_CLK_OFF: begin c.pwr_en = 1'b1; c.iso_en = 1'b1; end
            ST_ISO_ON:  begin c.pwr_en = 1'b1; c.iso_en = 1'b1; end
            ST_PWR_OFF: begin c.iso_en = 1'b1; end
            ST_SLEEP:   begin c.iso_en = 1'b1; c.asleep = 1'b1; c.busy = 1'b0; end
            ST_PWR_ON:  begin c.pwr_en = 1'b1; c.iso_en = 1'b1; end
            ST_SETTLE:  begin c.pwr_en = 1'b1; c.iso_en = 1'b1; end
            ST_CLK_ON:  begin c.clk_en = 1'b1; c.pwr_en = 1'b1; c.iso_en = 1'b1; end
            ST_RESTORE: begin c.clk_en = 1'b1; c.pwr_en = 1'b1; c.iso_en = 1'b1; c.restore = 1'b1; end
            ST_ISO_OFF: begin c.clk_en = 1'b1; c.pwr_en = 1'b1; end
            default:    c = RET_CTRL_RESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/retention_wait_timer.sv
// -----------------------------------------------------------------------------
// retention_wait_timer
// Saturating cycle counter for the settle delay and pwr_ack timeouts.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart counting (count is 0 in the following cycle)
//   limit      : number of cycles to wait
//   done       : high in the limit-th cycle since the last clear
// -----------------------------------------------------------------------------
module retention_wait_timer #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [CW-1:0] limit,
    output logic          done
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // r_cnt is 0 in the first cycle of a wait, so the limit-th cycle sees limit-1.
    assign done = (limit == '0) || (r_cnt >= (limit - CNT_ONE));

endmodule

// File: rtl/retention_power_ctrl.sv
// -----------------------------------------------------------------------------
// retention_power_ctrl
// Sequencer for a state-retention power domain: save -> gate clock -> isolate
// -> open switch on sleep, and the reverse with a settle delay on wake.
//   clk, rst_n           : clock, async active-low reset
//   sleep_req, wake_req  : level requests (both high in ACTIVE = stay awake)
//   pwr_ack              : switch status, 1 = domain powered
//   clr_err              : clears the sticky timeout flag
//   clk_en, save, restore, iso_en, pwr_en : registered domain controls
//   asleep, busy, err, state              : registered status
// -----------------------------------------------------------------------------
module retention_power_ctrl
    import retention_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int PWR_TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       pwr_ack,
    input  logic       clr_err,
    output logic       clk_en,
    output logic       save,
    output logic       restore,
    output logic       iso_en,
    output logic       pwr_en,
    output logic       asleep,
    output logic       busy,
    output logic       err,
    output logic [3:0] state
);

    localparam int WAIT_MAX = (PWR_TIMEOUT > SETTLE_CYCLES) ? PWR_TIMEOUT : SETTLE_CYCLES;
    localparam int CW       = $clog2(WAIT_MAX) + 1;
    localparam logic [CW-1:0] SETTLE_LIM  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LIM = CW'(PWR_TIMEOUT);

    ret_state_e    r_state, w_next;
    ret_ctrl_t     r_ctrl;
    logic          r_err;
    logic          r_pending;
    logic          w_timeout;
    logic          w_clear;
    logic          w_done;
    logic          w_down_seq;
    logic [CW-1:0] w_limit;

    assign w_limit    = (r_state == ST_SETTLE) ? SETTLE_LIM : TIMEOUT_LIM;
    // A PWR_ON timeout restarts the count without leaving the state.
    assign w_clear    = (w_next != r_state) || w_timeout;
    assign w_down_seq = (r_state == ST_SAVE) || (r_state == ST_CLK_OFF) ||
                        (r_state == ST_ISO_ON) || (r_state == ST_PWR_OFF);

    retention_wait_timer #(.CW(CW)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .limit (w_limit),
        .done  (w_done)
    );

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_ACTIVE:  if (sleep_req && !wake_req) w_next = ST_SAVE;
            ST_SAVE:    w_next = ST_CLK_OFF;
            ST_CLK_OFF: w_next = ST_ISO_ON;
            ST_ISO_ON:  w_next = ST_PWR_OFF;
            ST_PWR_OFF: begin
                if (!pwr_ack) begin
                    w_next = ST_SLEEP;
                end else if (w_done) begin
                    // switch never opened: abort back up the wake path
                    w_next    = ST_PWR_ON;
                    w_timeout = 1'b1;
                end
            end
            ST_SLEEP:   if (r_pending || wake_req) w_next = ST_PWR_ON;
            ST_PWR_ON: begin
                if (pwr_ack) begin
                    w_next = ST_SETTLE;
                end else if (w_done) begin
                    w_timeout = 1'b1;
                end
            end
            ST_SETTLE:  if (w_done) w_next = ST_CLK_ON;
            ST_CLK_ON:  w_next = ST_RESTORE;
            ST_RESTORE: w_next = ST_ISO_OFF;
            ST_ISO_OFF: w_next = ST_ACTIVE;
            default:    w_next = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACTIVE;
            r_ctrl  <= RET_CTRL_RESET;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ret_decode(w_next);
        end
    end

    // A wake arriving mid power-down is remembered so SLEEP hands straight
    // back to PWR_ON; entering PWR_ON consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if ((w_next == ST_PWR_ON) && (r_state != ST_PWR_ON)) begin
            r_pending <= 1'b0;
        end else if (w_down_seq && wake_req) begin
            r_pending <= 1'b1;
        end
    end

    // Timeout has priority over clr_err so a coincident event is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign clk_en  = r_ctrl.clk_en;
    assign pwr_en  = r_ctrl.pwr_en;
    assign iso_en  = r_ctrl.iso_en;
    assign save    = r_ctrl.save;
    assign restore = r_ctrl.restore;
    assign asleep  = r_ctrl.asleep;
    assign busy    = r_ctrl.busy;
    assign err     = r_err;
    assign state   = r_state;

endmodule

// File: tb/tb_retention_power_ctrl.sv
// -----------------------------------------------------------------------------
// tb_retention_power_ctrl
// Directed bench: expected per-cycle state/outputs are queued as each step is
// driven and popped at every falling edge.  A small power-switch model returns
// pwr_ack a programmable number of cycles after pwr_en, or a forced value.
// -----------------------------------------------------------------------------
module tb_retention_power_ctrl;

    localparam logic [3:0] S_A  = 4'd0,  S_SV = 4'd1, S_CO = 4'd2, S_IO = 4'd3,
                           S_PO = 4'd4,  S_SL = 4'd5, S_PN = 4'd6, S_ST = 4'd7,
                           S_CN = 4'd8,  S_RS = 4'd9, S_IF = 4'd10;

    logic       clk, rst_n, sleep_req, wake_req, pwr_ack, clr_err;
    logic       clk_en, save, restore, iso_en, pwr_en, asleep, busy, err;
    logic [3:0] state;
    logic [6:0] w_outs;

    typedef struct {
        logic [3:0] st;
        logic [6:0] outs;
        logic       err;
        string      tag;
    } exp_t;

    exp_t  exp_q[$];
    string step = "reset";
    int    n_tests = 0;
    int    n_fail  = 0;

    logic [2:0] ack_dly   = 3'd0;
    logic       ack_force = 1'b0;
    logic       ack_val   = 1'b0;
    logic [7:0] en_hist   = 8'hFF;

    assign w_outs = {clk_en, pwr_en, iso_en, save, restore, asleep, busy};

    retention_power_ctrl #(.SETTLE_CYCLES(4), .PWR_TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sleep_req (sleep_req),
        .wake_req  (wake_req),
        .pwr_ack   (pwr_ack),
        .clr_err   (clr_err),
        .clk_en    (clk_en),
        .save      (save),
        .restore   (restore),
        .iso_en    (iso_en),
        .pwr_en    (pwr_en),
        .asleep    (asleep),
        .busy      (busy),
        .err       (err),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {clk_en, pwr_en, iso_en, save, restore, asleep, busy} required in each state
    function automatic logic [6:0] exp_outs(input logic [3:0] st);
        case (st)
            S_A:     return 7'b1100000;
            S_SV:    return 7'b1101001;
            S_CO:    return 7'b0110001;
            S_IO:    return 7'b0110001;
            S_PO:    return 7'b0010001;
            S_SL:    return 7'b0010010;
            S_PN:    return 7'b0110001;
            S_ST:    return 7'b0110001;
            S_CN:    return 7'b1110001;
            S_RS:    return 7'b1110101;
            S_IF:    return 7'b1100001;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/state"}, {12'd0, state}, {12'd0, S_A});
        check({tag, "/outs"},  {9'd0, w_outs}, {9'd0, 7'b1100000});
        check({tag, "/err"},   {15'd0, err},   16'd0);
    endtask

    task automatic push(input logic [3:0] st, input logic e, input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            x.st   = st;
            x.outs = exp_outs(st);
            x.err  = e;
            x.tag  = step;
            exp_q.push_back(x);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() > 0 && b < 100) begin
            tick();
            b++;
        end
        check({step, "/drained"}, {15'd0, exp_q.size() == 0}, 16'd1);
        exp_q.delete();
    endtask

    // power switch: ack follows pwr_en after ack_dly falling edges, unless forced
    initial begin
        logic [7:0] h;
        forever begin
            @(negedge clk);
            h       = {en_hist[6:0], pwr_en};
            en_hist = h;
            pwr_ack = ack_force ? ack_val : h[ack_dly];
        end
    end

    // per-cycle scoreboard pop and ordering invariants
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("ordering", {15'd0, ((clk_en && pwr_en) || iso_en) &&
                                          (clk_en || !(save || restore)) &&
                                          !(save && restore)}, 16'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({e.tag, "/state"}, {12'd0, state}, {12'd0, e.st});
                    check({e.tag, "/outs"},  {9'd0, w_outs}, {9'd0, e.outs});
                    check({e.tag, "/err"},   {15'd0, err},   {15'd0, e.err});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sleep_req = 1'b0; wake_req = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        check_reset("reset");
        #1 rst_n = 1'b1;

        // full cycle, ack trails pwr_en by 2 cycles
        step = "full_sleep"; ack_dly = 3'd2;
        sleep_req = 1'b1;
        push(S_SV, 0, 1); push(S_CO, 0, 1); push(S_IO, 0, 1);
        push(S_PO, 0, 3); push(S_SL, 0, 3);
        tick(); sleep_req = 1'b0;
        drain();
        step = "full_wake";
        wake_req = 1'b1;
        push(S_PN, 0, 3); push(S_ST, 0, 4); push(S_CN, 0, 1);
        push(S_RS, 0, 1); push(S_IF, 0, 1); push(S_A, 0, 2);
        tick(); wake_req = 1'b0;
        drain();

        // minimum latencies with immediate ack: 5 to asleep, 9 back to ACTIVE
        step = "lat_sleep"; ack_dly = 3'd0;
        sleep_req = 1'b1;
        push(S_SV, 0, 1); push(S_CO, 0, 1); push(S_IO, 0, 1);
        push(S_PO, 0, 1); push(S_SL, 0, 2);
        tick(); sleep_req = 1'b0;
        drain();
        step = "lat_wake";
        wake_req = 1'b1;
        push(S_PN, 0, 1); push(S_ST, 0, 4); push(S_CN, 0, 1);
        push(S_RS, 0, 1); push(S_IF, 0, 1); push(S_A, 0, 1);
        tick(); wake_req = 1'b0;
        drain();

        // sleep and wake together in ACTIVE: no sequence starts
        step = "both_req";
        sleep_req = 1'b1; wake_req = 1'b1;
        push(S_A, 0, 3);
        drain();
        sleep_req = 1'b0; wake_req = 1'b0;
        push(S_A, 0, 1);
        drain();

        // wake pulse during CLK_OFF: one SLEEP cycle then straight up
        step = "early_wake";
        sleep_req = 1'b1;
        push(S_SV, 0, 1); push(S_CO, 0, 1); push(S_IO, 0, 1); push(S_PO, 0, 1);
        push(S_SL, 0, 1); push(S_PN, 0, 1); push(S_ST, 0, 4); push(S_CN, 0, 1);
        push(S_RS, 0, 1); push(S_IF, 0, 1); push(S_A, 0, 1);
        tick(); sleep_req = 1'b0;
        tick(); wake_req = 1'b1;
        tick(); wake_req = 1'b0;
        drain();

        // switch never opens: err after 8 PWR_OFF cycles, abort to wake path
        step = "down_timeout"; ack_force = 1'b1; ack_val = 1'b1;
        sleep_req = 1'b1;
        push(S_SV, 0, 1); push(S_CO, 0, 1); push(S_IO, 0, 1); push(S_PO, 0, 8);
        push(S_PN, 1, 1); push(S_ST, 1, 4); push(S_CN, 1, 1); push(S_RS, 1, 1);
        push(S_IF, 1, 1); push(S_A, 1, 1);
        tick(); sleep_req = 1'b0;
        drain();
        step = "clr_err"; ack_force = 1'b0;
        clr_err = 1'b1;
        push(S_A, 0, 1);
        tick(); clr_err = 1'b0;
        push(S_A, 0, 1);
        drain();

        // switch never closes: timeout keeps waiting; clr_err on the timeout
        // cycle loses, one cycle later it wins
        step = "up_sleep";
        sleep_req = 1'b1;
        push(S_SV, 0, 1); push(S_CO, 0, 1); push(S_IO, 0, 1);
        push(S_PO, 0, 1); push(S_SL, 0, 2);
        tick(); sleep_req = 1'b0;
        drain();
        step = "up_timeout"; ack_force = 1'b1; ack_val = 1'b0;
        wake_req = 1'b1;
        push(S_PN, 0, 8); push(S_PN, 1, 1); push(S_PN, 0, 2); push(S_ST, 0, 4);
        push(S_CN, 0, 1); push(S_RS, 0, 1); push(S_IF, 0, 1); push(S_A, 0, 1);
        tick(); wake_req = 1'b0;
        repeat (7) tick();
        clr_err = 1'b1;
        tick();
        tick(); clr_err = 1'b0; ack_force = 1'b0;
        drain();

        // reset while waiting in PWR_OFF
        step = "rst_pwr_off"; ack_dly = 3'd2;
        sleep_req = 1'b1;
        push(S_SV, 0, 1); push(S_CO, 0, 1); push(S_IO, 0, 1); push(S_PO, 0, 1);
        tick(); sleep_req = 1'b0;
        drain();
        rst_n = 1'b0;
        #1 check_reset("rst_pwr_off_now");
        @(negedge clk);
        check_reset("rst_pwr_off_hold");
        #1 rst_n = 1'b1;
        push(S_A, 0, 2);
        drain();

        // reset while in SLEEP: back to ACTIVE and stays there
        step = "rst_sleep"; ack_dly = 3'd0;
        sleep_req = 1'b1;
        push(S_SV, 0, 1); push(S_CO, 0, 1); push(S_IO, 0, 1);
        push(S_PO, 0, 1); push(S_SL, 0, 2);
        tick(); sleep_req = 1'b0;
        drain();
        rst_n = 1'b0;
        #1 check_reset("rst_sleep_now");
        tick(); rst_n = 1'b1;
        push(S_A, 0, 3);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
